// File: rtl/spi_peripheral_if.sv
// Bundle of SPI pins and register outputs shared between an SPI controller
// (master side) and the spi_peripheral register block (slave side).
`timescale 1ns/1ps
interface spi_peripheral_if;
  logic       sclk;
  logic       ncs;
  logic       copi;
  logic [7:0] en_reg_out_7_0;
  logic [7:0] en_reg_out_15_8;
  logic [7:0] en_reg_pwm_7_0;
  logic [7:0] en_reg_pwm_15_8;
  logic [7:0] pwm_duty_cycle;
  logic       wr_strobe;

  modport master (
    output sclk, ncs, copi,
    input  en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8,
           pwm_duty_cycle, wr_strobe
  );

  modport slave (
    input  sclk, ncs, copi,
    output en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8,
           pwm_duty_cycle, wr_strobe
  );
endinterface

// File: rtl/spi_peripheral.sv
// SPI mode-0 write-only register file: 16-bit frames {wr, addr[6:0], data[7:0]}
// are oversampled on clk and committed to one of five 8-bit registers on ncs rise.
`timescale 1ns/1ps
module spi_peripheral #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [6:0]  MAX_ADDR    = 7'h04
) (
  input logic             clk,
  input logic             rst_n,
  spi_peripheral_if.slave bus
);

  typedef enum logic {IDLE, ACTIVE} state_e;

  localparam int unsigned NUM_REGS   = 5;
  localparam logic [6:0]  LAST_REG   = 7'(NUM_REGS - 1);
  localparam logic [4:0]  FRAME_BITS = 5'd16;
  localparam logic [4:0]  CNT_SAT    = 5'd17;

  logic [SYNC_STAGES-1:0] sclkSync_q;
  logic [SYNC_STAGES-1:0] ncsSync_q;
  logic [SYNC_STAGES-1:0] copiSync_q;
  logic [SYNC_STAGES-1:0] syncValid_q;
  logic                   sclkPrev_q;
  logic                   ncsPrev_q;
  logic                   armed_q;
  state_e                 state_q;
  logic [15:0]            shift_q;
  logic [15:0]            shift_d;
  logic [4:0]             bitCnt_q;
  logic [4:0]             bitCnt_d;
  logic [7:0]             regs_q [NUM_REGS];
  logic                   wrStrobe_q;

  logic       sclkS;
  logic       ncsS;
  logic       copiS;
  logic       syncReady;
  logic       sclkRise;
  logic       ncsFall;
  logic       ncsRise;
  logic       commitOk;
  logic [6:0] frameAddr;

  // Reset values model an idle bus (sclk low, ncs high) so reset itself makes no edges.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sclkSync_q  <= '0;
      ncsSync_q   <= '1;
      copiSync_q  <= '0;
      syncValid_q <= '0;
      sclkPrev_q  <= 1'b0;
      ncsPrev_q   <= 1'b1;
    end else begin
      sclkSync_q  <= {sclkSync_q[SYNC_STAGES-2:0], bus.sclk};
      ncsSync_q   <= {ncsSync_q[SYNC_STAGES-2:0], bus.ncs};
      copiSync_q  <= {copiSync_q[SYNC_STAGES-2:0], bus.copi};
      syncValid_q <= {syncValid_q[SYNC_STAGES-2:0], 1'b1};
      sclkPrev_q  <= sclkS;
      ncsPrev_q   <= ncsS;
    end
  end

  assign sclkS     = sclkSync_q[SYNC_STAGES-1];
  assign ncsS      = ncsSync_q[SYNC_STAGES-1];
  assign copiS     = copiSync_q[SYNC_STAGES-1];
  assign syncReady = syncValid_q[SYNC_STAGES-1];

  assign sclkRise  = ~sclkPrev_q & sclkS;
  assign ncsFall   = ncsPrev_q & ~ncsS;
  assign ncsRise   = ~ncsPrev_q & ncsS;

  assign frameAddr = shift_q[14:8];
  assign commitOk  = (bitCnt_q == FRAME_BITS) && shift_q[15] &&
                     (frameAddr <= MAX_ADDR) && (frameAddr <= LAST_REG);

  always_comb begin
    shift_d  = {shift_q[14:0], copiS};
    bitCnt_d = (bitCnt_q == CNT_SAT) ? bitCnt_q : bitCnt_q + 5'd1;
  end

  // armed_q blocks a frame already in progress at reset release: a fall only
  // counts once the flushed synchronizer has shown ncs genuinely high.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      bitCnt_q   <= '0;
      wrStrobe_q <= 1'b0;
      armed_q    <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      wrStrobe_q <= 1'b0;
      if (syncReady && ncsS) begin
        armed_q <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (ncsFall && armed_q) begin
            state_q  <= ACTIVE;
            shift_q  <= '0;
            bitCnt_q <= '0;
          end
        end
        ACTIVE: begin
          if (ncsRise) begin
            state_q <= IDLE;
            if (commitOk) begin
              wrStrobe_q <= 1'b1;
              for (int i = 0; i < NUM_REGS; i++) begin
                if (frameAddr == 7'(i)) begin
                  regs_q[i] <= shift_q[7:0];
                end
              end
            end
          end else if (sclkRise) begin
            shift_q  <= shift_d;
            bitCnt_q <= bitCnt_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.en_reg_out_7_0  = regs_q[0];
  assign bus.en_reg_out_15_8 = regs_q[1];
  assign bus.en_reg_pwm_7_0  = regs_q[2];
  assign bus.en_reg_pwm_15_8 = regs_q[3];
  assign bus.pwm_duty_cycle  = regs_q[4];
  assign bus.wr_strobe       = wrStrobe_q;

endmodule

// File: tb/tb_spi_peripheral.sv
// Self-checking bench for spi_peripheral: directed frame table, reset and
// edge-coincidence sequences, then random frames against a register-file model.
`timescale 1ns/1ps
module tb_spi_peripheral;

  localparam int SYNC = 2;
  localparam int HALF = 400;

  typedef struct {
    string       name;
    logic [23:0] bits;
    int          nbits;
    logic [39:0] expRegs;
    int          expStrobes;
  } vector_t;

  logic clk = 1'b0;
  logic rst_n;
  int   testsRun = 0;
  int   testsFailed = 0;
  int   strobeCount = 0;
  logic [7:0] model [5];
  vector_t vecs[$];

  spi_peripheral_if bus();

  spi_peripheral #(.SYNC_STAGES(SYNC), .MAX_ADDR(7'h04)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #50 clk = ~clk;

  always @(negedge clk) begin
    if (bus.wr_strobe === 1'b1) strobeCount++;
  end

  task automatic addVec(input string name, input logic [23:0] bits, input int nbits,
                        input logic [39:0] expRegs, input int expStrobes);
    vector_t v;
    v.name = name;
    v.bits = bits;
    v.nbits = nbits;
    v.expRegs = expRegs;
    v.expStrobes = expStrobes;
    vecs.push_back(v);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Packed as {reg4, reg3, reg2, reg1, reg0}.
  function automatic logic [39:0] dutRegs();
    return {bus.pwm_duty_cycle, bus.en_reg_pwm_15_8, bus.en_reg_pwm_7_0,
            bus.en_reg_out_15_8, bus.en_reg_out_7_0};
  endfunction

  function automatic logic [39:0] packModel();
    return {model[4], model[3], model[2], model[1], model[0]};
  endfunction

  task automatic checkRegs(input string name, input logic [39:0] expRegs);
    logic [39:0] act;
    act = dutRegs();
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("%s.reg%0d", name, i), 32'(act[i*8 +: 8]), 32'(expRegs[i*8 +: 8]));
    end
  endtask

  task automatic sendBits(input logic [23:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      bus.copi = bits[i];
      #HALF bus.sclk = 1'b1;
      #HALF bus.sclk = 1'b0;
    end
  endtask

  task automatic endFrame(input string name, input logic [39:0] expRegs, input int expStrobes);
    int s0;
    #HALF;
    @(negedge clk);
    #1;
    s0 = strobeCount;
    bus.ncs = 1'b1;
    repeat (SYNC + 2) @(posedge clk);
    #1;
    checkRegs(name, expRegs);
    checkOutput({name, ".strobeOnTime"}, 32'(strobeCount - s0), 32'(expStrobes));
    repeat (3) @(posedge clk);
    #1;
    checkOutput({name, ".strobeTotal"}, 32'(strobeCount - s0), 32'(expStrobes));
  endtask

  task automatic applyStimulus(input string name, input logic [23:0] bits, input int n,
                               input logic [39:0] expRegs, input int expStrobes);
    #($urandom_range(0, 99));
    bus.ncs = 1'b0;
    #HALF;
    sendBits(bits, n);
    endFrame(name, expRegs, expStrobes);
  endtask

  task automatic pulseReset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int          kind;
    int          n;
    int          expS;
    logic [23:0] bits;
    logic [6:0]  addr;
    logic [7:0]  data;

    bus.sclk = 1'b0;
    bus.ncs  = 1'b1;
    bus.copi = 1'b0;
    rst_n    = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkRegs("reset", 40'h0);
    checkOutput("reset.strobe", 32'(bus.wr_strobe), 32'h0);
    repeat (8) @(posedge clk);

    addVec("wr0_F0",    24'h0080F0, 16, 40'h00_00_00_00_F0, 1);
    addVec("wr4_80",    24'h008480, 16, 40'h80_00_00_00_F0, 1);
    addVec("wr2_01",    24'h008201, 16, 40'h80_00_01_00_F0, 1);
    addVec("read00AA",  24'h0000AA, 16, 40'h80_00_01_00_F0, 0);
    addVec("wrAddr5",   24'h0085AA, 16, 40'h80_00_01_00_F0, 0);
    addVec("short15",   24'h0040D5, 15, 40'h80_00_01_00_F0, 0);
    addVec("long17",    24'h010356, 17, 40'h80_00_01_00_F0, 0);
    addVec("wr1_AB",    24'h0081AB, 16, 40'h80_00_01_AB_F0, 1);
    addVec("wrAddr7F",  24'h00FFFF, 16, 40'h80_00_01_AB_F0, 0);
    addVec("wr3_3C",    24'h00833C, 16, 40'h80_3C_01_AB_F0, 1);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].name, vecs[i].bits, vecs[i].nbits, vecs[i].expRegs, vecs[i].expStrobes);
    end

    model[0] = 8'hF0; model[1] = 8'hAB; model[2] = 8'h01; model[3] = 8'h3C; model[4] = 8'h80;

    // ncs fall and sclk rise together: that sclk edge must not be counted.
    #($urandom_range(0, 99));
    bus.copi = 1'b1;
    bus.ncs  = 1'b0;
    bus.sclk = 1'b1;
    #HALF bus.sclk = 1'b0;
    sendBits(24'h008277, 16);
    model[2] = 8'h77;
    endFrame("ncsFallSclkRise", packModel(), 1);

    // Reset after 8 bits, released with ncs still low, then frame finished.
    bus.ncs = 1'b0;
    #HALF;
    sendBits(24'h000081, 8);
    pulseReset();
    sendBits(24'h000033, 8);
    for (int i = 0; i < 5; i++) model[i] = 8'h00;
    endFrame("resetMidFrame", packModel(), 0);

    // Reset released with ncs low, followed by a complete valid frame.
    bus.ncs = 1'b0;
    #HALF;
    pulseReset();
    #HALF;
    sendBits(24'h008133, 16);
    endFrame("resetNcsLow", packModel(), 0);

    model[1] = 8'h33;
    applyStimulus("afterReset", 24'h008133, 16, packModel(), 1);

    for (int k = 0; k < 200; k++) begin
      kind = $urandom_range(0, 9);
      data = 8'($urandom);
      addr = 7'($urandom_range(0, 4));
      bits = 24'($urandom);
      n    = 16;
      if (kind <= 5) begin
        bits = {8'h00, 1'b1, addr, data};
      end else if (kind == 6) begin
        bits = {8'h00, 1'b0, 7'($urandom), data};
      end else if (kind == 7) begin
        addr = 7'($urandom_range(5, 127));
        bits = {8'h00, 1'b1, addr, data};
      end else if (kind == 8) begin
        n = $urandom_range(8, 15);
      end else begin
        n = $urandom_range(17, 20);
      end

      expS = 0;
      if (n == 16 && bits[15] == 1'b1 && int'(bits[14:8]) <= 4) begin
        model[int'(bits[14:8])] = bits[7:0];
        expS = 1;
      end
      applyStimulus($sformatf("rand%0d", k), bits, n, packModel(), expS);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/spi_peripheral.md
SPI_PERIPHERAL -- requirements
Module: spi_peripheral

Interface
REQ-001 Parameter SYNC_STAGES, default 2, synchronizer depth on sclk/ncs/copi; legal values >= 2.
REQ-002 Parameter MAX_ADDR, default 7'h04, highest writable register address.
REQ-003 clk  input  1  system clock, 10 MHz.
REQ-004 rst_n  input  1  reset, synchronous, active-low; sampled on clk rising edge only.
REQ-005 sclk  input  1  SPI serial clock, asynchronous to clk.
REQ-006 ncs  input  1  SPI chip select, active-low, asynchronous to clk.
REQ-007 copi  input  1  SPI controller-out/peripheral-in data, asynchronous to clk.
REQ-008 en_reg_out_7_0  output  8  register 0x00, output enables for uo_out[7:0].
REQ-009 en_reg_out_15_8  output  8  register 0x01, output enables for uio_out[7:0].
REQ-010 en_reg_pwm_7_0  output  8  register 0x02, PWM mode for uo_out[7:0].
REQ-011 en_reg_pwm_15_8  output  8  register 0x03, PWM mode for uio_out[7:0].
REQ-012 pwm_duty_cycle  output  8  register 0x04, shared PWM duty, 0..255.
REQ-013 wr_strobe  output  1  one-cycle pulse marking a committed register write.

Function
REQ-014 sclk, ncs, copi SHALL each pass through a SYNC_STAGES-deep flop chain clocked by clk; all logic below SHALL use only the last stage (sclk_s, ncs_s, copi_s).
REQ-015 A registered copy of sclk_s and ncs_s SHALL be held; sclk rise = prev 0 & now 1; ncs fall = prev 1 & now 0; ncs rise = prev 0 & now 1.
REQ-016 States SHALL be IDLE and ACTIVE; IDLE->ACTIVE on ncs fall; ACTIVE->IDLE on ncs rise; no other transitions.
REQ-017 Entering ACTIVE SHALL clear the 16-bit shift register and 5-bit bit counter in the same cycle.
REQ-018 In ACTIVE, each sclk rise SHALL shift copi_s into shift register bit 0 (MSB first) and increment the counter, saturating at 17.
REQ-019 sclk rises in IDLE SHALL be ignored; SPI mode 0 (sample on rising SCLK) only.
REQ-020 Frame format: bit15 = R/W (1 = write), bits14:8 = address, bits7:0 = data.
REQ-021 On the ncs-rise cycle a write SHALL commit iff counter == 16, bit15 == 1 and address <= MAX_ADDR; the addressed register SHALL take the data on that clk edge.
REQ-022 Frames with counter != 16 (short or long), bit15 == 0 (read), or address > MAX_ADDR SHALL be discarded with no register change and no wr_strobe.
REQ-023 wr_strobe SHALL be 1 for exactly the cycle after a commit edge, coincident with the new register value first visible, else 0.
REQ-024 Committed value SHALL be visible on outputs at most SYNC_STAGES+2 clk rising edges after ncs rises at the pin.
REQ-025 Register outputs SHALL hold their value between commits; unaddressed registers SHALL never change.
REQ-026 ncs fall and sclk rise detected in the same cycle: clear takes effect, that sclk edge is not counted.
REQ-027 Back-to-back frames with ncs high for >= SYNC_STAGES+1 clk cycles SHALL both be processed.

Reset
REQ-028 While rst_n == 0 at a clk edge: all five registers = 8'h00, wr_strobe = 0, state = IDLE, counter = 0, shift register = 0.
REQ-029 Synchronizer stages and prev copies SHALL reset to sclk 0, ncs 1, copi 0.
REQ-030 Reset asserted mid-frame SHALL abort the frame; if ncs is low at reset release, that frame SHALL be ignored until ncs is seen high and falls again.

Verification
REQ-031 Reset, then write 0x00 <- 8'hF0 (frame 16'h80F0) -> en_reg_out_7_0 = 8'hF0, one wr_strobe pulse, others 8'h00.
REQ-032 Write 0x04 <- 8'h80 then 0x02 <- 8'h01 back-to-back -> pwm_duty_cycle = 8'h80, en_reg_pwm_7_0 = 8'h01, two strobes.
REQ-033 Read frame 16'h00AA and write to address 0x05 (16'h85AA) -> all registers unchanged, no wr_strobe.
REQ-034 15-bit and 17-bit frames targeting 0x01 -> en_reg_out_15_8 unchanged, no wr_strobe.
REQ-035 Assert rst_n = 0 after 8 bits of frame 16'h8133, release with ncs low, finish frame -> all registers 8'h00, no wr_strobe.
REQ-036 SCLK at clk/8 with random clk-phase offset, 200 random frames -> register contents match a reference model after every frame.
